// File: rtl/reliability_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reliability_pkg
// Description : Shared types and defaults for the reliability accumulator.
//               Holds the combine-mode enum, the controller state enum and the
//               default probability / beat-counter widths.
// Revision    : 1.0 - initial release
// ============================================================================
package reliability_pkg;

    // Default probability width (unsigned Q0.W fraction).
    localparam int c_default_w  = 8;
    // Default beat-counter width.
    localparam int c_default_cw = 4;

    typedef enum logic [0:0] {
        SERIES   = 1'b0,
        PARALLEL = 1'b1
    } mode_t;

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/reliability_fxmul.sv
`default_nettype none
// ============================================================================
// Module      : reliability_fxmul
// Description : Combinational Q0.W fixed-point multiply, y = (a*b) >> W.
//               With RELIABILITY_ACCUM_ROUND_EN defined the product is rounded
//               half up, y = (a*b + 2^(W-1)) >> W; otherwise it truncates.
// Ports       : i_a [W-1:0] - first operand
//               i_b [W-1:0] - second operand
//               o_y [W-1:0] - scaled product
// Revision    : 1.0 - initial release
// ============================================================================
module reliability_fxmul #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_y
);

    logic [2*W-1:0] w_prod;
    logic [2*W-1:0] w_sum;

    // Zero-extend both operands so the full 2W-bit product is formed.
    assign w_prod = {{W{1'b0}}, i_a} * {{W{1'b0}}, i_b};

`ifdef RELIABILITY_ACCUM_ROUND_EN
    // Half an LSB of the result; (2^W-1)^2 + 2^(W-1) still fits in 2W bits.
    localparam logic [2*W-1:0] c_half = (2*W)'(1) << (W - 1);
    assign w_sum = w_prod + c_half;
`else
    assign w_sum = w_prod;
`endif

    assign o_y = W'(w_sum >> W);

endmodule
`default_nettype wire

// File: rtl/reliability_accum.sv
`default_nettype none
// ============================================================================
// Module      : reliability_accum
// Description : Combines a set of component reliabilities (Q0.W fractions)
//               in series (product of p) or parallel (1 - product of (1-p)).
//               A set is a run of accepted beats terminated by in_last; the
//               result is presented one cycle later under a valid/ready
//               handshake. Option macro: RELIABILITY_ACCUM_ROUND_EN selects
//               round-half-up multiplication instead of truncation.
// Ports       : clk        - clock, rising edge
//               rst_n      - synchronous active-low reset
//               in_p       - component reliability of the current beat
//               in_mode    - 0 series / 1 parallel, taken from the first beat
//               in_valid   - input beat offered
//               in_ready   - input beat can be accepted
//               in_last    - final component of the set
//               out_r      - combined reliability
//               out_cnt    - beats combined, saturating
//               out_valid  - result available
//               out_ready  - result consumed
// Revision    : 1.0 - initial release
// ============================================================================
module reliability_accum
    import reliability_pkg::*;
#(
    parameter int W  = c_default_w,
    parameter int CW = c_default_cw
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  in_p,
    input  logic          in_mode,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_last,
    output logic [W-1:0]  out_r,
    output logic [CW-1:0] out_cnt,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam logic [CW-1:0] c_cnt_max = '1;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_first;
    mode_t         r_mode;
    logic [W-1:0]  r_acc;
    logic [CW-1:0] r_cnt;

    logic          w_beat;
    mode_t         w_mode_eff;
    logic [W-1:0]  w_term;
    logic [W-1:0]  w_prod;
    logic [W-1:0]  w_acc_nxt;
    logic [CW-1:0] w_cnt_nxt;

    assign w_beat = in_valid && in_ready;

    // Mode is only sampled on the first beat of a set; later beats use the
    // latched value regardless of in_mode.
    assign w_mode_eff = r_first ? mode_t'(in_mode) : r_mode;

    // Parallel sets accumulate the product of failure probabilities (~p) and
    // complement once at the output.
    assign w_term = (w_mode_eff == PARALLEL) ? ~in_p : in_p;

    reliability_fxmul #(
        .W (W)
    ) u_fxmul (
        .i_a (r_acc),
        .i_b (w_term),
        .o_y (w_prod)
    );

    assign w_acc_nxt = r_first ? w_term : w_prod;
    assign w_cnt_nxt = r_first              ? CW'(1) :
                       (r_cnt == c_cnt_max) ? r_cnt  :
                                              r_cnt + 1'b1;

    // Next-state and output decode.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_r       = '0;
        out_cnt     = '0;
        case (r_state)
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                out_r     = (r_mode == PARALLEL) ? ~r_acc : r_acc;
                out_cnt   = r_cnt;
                if (out_ready) begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            default: begin
                w_state_nxt = ST_ACCUM;
            end
        endcase
    end

    // State and datapath registers. No beats are accepted in DONE, so acc,
    // cnt and mode hold the result steady until it is consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_ACCUM;
            r_first <= 1'b1;
            r_mode  <= SERIES;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_beat) begin
                r_first <= 1'b0;
                r_acc   <= w_acc_nxt;
                r_cnt   <= w_cnt_nxt;
                if (r_first) begin
                    r_mode <= w_mode_eff;
                end
            end
            if ((r_state == ST_DONE) && out_ready) begin
                r_first <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reliability_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_reliability_accum
// Description : Self-checking bench for reliability_accum (W = 8, CW = 4).
//               Directed vectors for the reference cases followed by random
//               sets, all compared against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reliability_accum;

    localparam int W  = 8;
    localparam int CW = 4;
    localparam int c_pmax   = (1 << W) - 1;
    localparam int c_cntmax = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  in_p;
    logic          in_mode;
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic [W-1:0]  out_r;
    logic [CW-1:0] out_cnt;
    logic          out_valid;
    logic          out_ready;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0]  set_p [0:31];
    logic [W-1:0]  cap_r;
    logic [CW-1:0] cap_cnt;

    always #5 clk = ~clk;

    reliability_accum #(
        .W  (W),
        .CW (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_p      (in_p),
        .in_mode   (in_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .out_r     (out_r),
        .out_cnt   (out_cnt),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference fixed-point multiply from the arithmetic definition.
    function automatic int fx(input int a, input int b);
`ifdef RELIABILITY_ACCUM_ROUND_EN
        return (a * b + (1 << (W - 1))) >> W;
`else
        return (a * b) >> W;
`endif
    endfunction

    // Series: product of p. Parallel: 1 - product of (1 - p), all in Q0.W.
    function automatic int model_r(input int n, input bit md);
        int acc;
        int term;
        acc = md ? c_pmax - int'(set_p[0]) : int'(set_p[0]);
        for (int i = 1; i < n; i++) begin
            term = md ? c_pmax - int'(set_p[i]) : int'(set_p[i]);
            acc  = fx(acc, term);
        end
        return md ? c_pmax - acc : acc;
    endfunction

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_r", 32'(out_r), 32'd0);
            chk("rst_out_cnt", 32'(out_cnt), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    endtask

    // Sends set_p[0..n-1] as one set, checks the result one cycle after the
    // last beat, holds out_ready low for 'hold' cycles, then optionally acks.
    task automatic run_set(input int n, input bit md, input int hold,
                           input bit bubbles, input bit ack);
        int exp_r;
        int exp_cnt;
        exp_r   = model_r(n, md);
        exp_cnt = (n > c_cntmax) ? c_cntmax : n;
        for (int i = 0; i < n; i++) begin
            if (bubbles && ($urandom_range(0, 3) == 0)) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_p     = W'($urandom);
                in_last  = 1'($urandom);
                in_mode  = 1'($urandom);
            end
            @(negedge clk);
            chk("accum_in_ready", 32'(in_ready), 32'd1);
            chk("accum_out_valid", 32'(out_valid), 32'd0);
            in_valid = 1'b1;
            in_p     = set_p[i];
            in_mode  = (i == 0) ? md : 1'($urandom);
            in_last  = (i == n - 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("done_out_valid", 32'(out_valid), 32'd1);
        chk("done_out_r", 32'(out_r), 32'(exp_r));
        chk("done_out_cnt", 32'(out_cnt), 32'(exp_cnt));
        chk("done_in_ready", 32'(in_ready), 32'd0);
        cap_r   = out_r;
        cap_cnt = out_cnt;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_out_r", 32'(out_r), 32'(exp_r));
            chk("hold_out_cnt", 32'(out_cnt), 32'(exp_cnt));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        if (ack) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk("ack_out_valid", 32'(out_valid), 32'd0);
            chk("ack_in_ready", 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        in_p      = '0;
        in_mode   = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        do_reset(3);

        // Series 0xE6, 0xCC.
        set_p[0] = 8'hE6;
        set_p[1] = 8'hCC;
        run_set(2, 1'b0, 0, 1'b0, 1'b1);
        chk("series_e6cc_r", 32'(cap_r), 32'h0B7);
        chk("series_e6cc_cnt", 32'(cap_cnt), 32'd2);

        // Parallel 0xE6, 0xCC.
        run_set(2, 1'b1, 0, 1'b0, 1'b1);
`ifdef RELIABILITY_ACCUM_ROUND_EN
        chk("parallel_e6cc_r", 32'(cap_r), 32'h0FA);
`else
        chk("parallel_e6cc_r", 32'(cap_r), 32'h0FB);
`endif

        // Single beat, both modes.
        set_p[0] = 8'h5A;
        run_set(1, 1'b0, 0, 1'b0, 1'b1);
        chk("single_series_r", 32'(cap_r), 32'h05A);
        chk("single_series_cnt", 32'(cap_cnt), 32'd1);
        run_set(1, 1'b1, 0, 1'b0, 1'b1);
        chk("single_parallel_r", 32'(cap_r), 32'h05A);
        chk("single_parallel_cnt", 32'(cap_cnt), 32'd1);

        // Back-pressure for 5 cycles, then the next set must be accepted.
        for (int i = 0; i < 4; i++) set_p[i] = W'($urandom);
        run_set(4, 1'($urandom), 5, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) set_p[i] = W'($urandom);
        run_set(3, 1'($urandom), 0, 1'b0, 1'b1);

        // Counter saturation with 17 beats of 0xFF.
        for (int i = 0; i < 17; i++) set_p[i] = 8'hFF;
        run_set(17, 1'b0, 1, 1'b0, 1'b1);
        chk("sat_cnt", 32'(cap_cnt), 32'd15);

        // Reset in the middle of a set: partial result is discarded.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_p     = W'($urandom);
            in_mode  = 1'b1;
            in_last  = 1'b0;
        end
        do_reset(2);
        for (int i = 0; i < 3; i++) set_p[i] = W'($urandom);
        run_set(3, 1'b0, 0, 1'b0, 1'b1);

        // Reset while a result is pending in DONE.
        for (int i = 0; i < 3; i++) set_p[i] = W'($urandom);
        run_set(3, 1'b1, 1, 1'b0, 1'b0);
        do_reset(2);
        for (int i = 0; i < 2; i++) set_p[i] = W'($urandom);
        run_set(2, 1'b1, 0, 1'b0, 1'b1);

        // Random sets with bubbles and back-pressure.
        for (int s = 0; s < 25; s++) begin
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) set_p[i] = W'($urandom);
            run_set(n, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b1, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
